// File: rtl/h264_dh_pkg.sv
// h264_dh_pkg: shared scan-counter command encoding and frame geometry defaults
package h264_dh_pkg;
  typedef enum logic [1:0] {
    CNT_CLEAR = 2'b00,
    CNT_HOLD  = 2'b01,
    CNT_STEP  = 2'b10,
    CNT_NEXT  = 2'b11
  } cnt_cmd_e;
  localparam int MB_SIZE = 16;
  localparam int DEF_FRAME_W = 352;
  localparam int DEF_FRAME_H = 288;
endpackage

// File: rtl/mb_offset_counter.sv
// mb_offset_counter: 4-bit pixel offset inside a macroblock with command decode and at-15 flag
module mb_offset_counter
  import h264_dh_pkg::*;
#(
  parameter bit NEXT_STEPS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic [3:0] off,
  output logic       at_15
);
  logic [3:0] nxt;
  // the row counter treats NEXT as a step; the column counter treats it as a clear
  always_comb nxt = cmd == CNT_CLEAR ? 4'd0 :
                    cmd == CNT_HOLD ? off :
                    (cmd == CNT_NEXT && !NEXT_STEPS) ? 4'd0 : off + 4'd1;
  always_ff @(posedge clk)
    off <= reset ? 4'd0 : nxt;
  assign at_15 = off == 4'd15;
endmodule

// File: rtl/mb_scan_counter.sv
// mb_scan_counter: pixel/macroblock scan position, controller flags and registered fetch address
module mb_scan_counter
  import h264_dh_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          x_count,
  input  logic [1:0]                          y_count,
  output logic                                x_16,
  output logic                                y_16,
  output logic [$clog2(FRAME_W/MB_SIZE)-1:0]  mb_x,
  output logic [$clog2(FRAME_H/MB_SIZE)-1:0]  mb_y,
  output logic [ADDR_W-1:0]                   addr,
  output logic                                addr_valid,
  output logic                                frame_done
);
  localparam int MBS_X = FRAME_W / MB_SIZE;
  localparam int MBS_Y = FRAME_H / MB_SIZE;
  localparam int MBX_W = $clog2(MBS_X);
  localparam int MBY_W = $clog2(MBS_Y);
  logic [3:0] x_off, y_off;
  logic       next_mb, last_x, last_y;
  mb_offset_counter #(.NEXT_STEPS(1'b0)) u_x (
    .clk(clk), .reset(reset), .cmd(x_count), .off(x_off), .at_15(x_16)
  );
  mb_offset_counter #(.NEXT_STEPS(1'b1)) u_y (
    .clk(clk), .reset(reset), .cmd(y_count), .off(y_off), .at_15(y_16)
  );
  assign next_mb = x_count == CNT_NEXT;
  assign last_x  = mb_x == MBX_W'(MBS_X - 1);
  assign last_y  = mb_y == MBY_W'(MBS_Y - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      mb_x       <= '0;
      mb_y       <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (next_mb) mb_x <= last_x ? '0 : mb_x + 1'b1;
      if (next_mb && last_x) mb_y <= last_y ? '0 : mb_y + 1'b1;
      frame_done <= next_mb && last_x && last_y;
      addr_valid <= x_count == CNT_STEP;
      // address of the position held this cycle, products kept at 32 bits before truncation
      addr <= ADDR_W'((32'(mb_y) * MB_SIZE + 32'(y_off)) * FRAME_W + 32'(mb_x) * MB_SIZE + 32'(x_off));
    end
  end
endmodule

// File: tb/tb_mb_scan_counter.sv
// tb_mb_scan_counter: directed scan sequences with an address scoreboard and flag checks
module tb_mb_scan_counter;
  import h264_dh_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  x_count = CNT_HOLD;
  logic [1:0]  y_count = CNT_HOLD;
  logic        x_16, y_16, addr_valid, frame_done;
  logic [4:0]  mb_x, mb_y;
  logic [16:0] addr;
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_q[$];
  mb_scan_counter dut (
    .clk(clk), .reset(reset), .x_count(x_count), .y_count(y_count),
    .x_16(x_16), .y_16(y_16), .mb_x(mb_x), .mb_y(mb_y),
    .addr(addr), .addr_valid(addr_valid), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic int pix(int mx, int my, int xo, int yo);
    return (my * 16 + yo) * 352 + mx * 16 + xo;
  endfunction
  task automatic chk(string n, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (addr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_fetch", int'(addr), -1);
      else chk("addr", int'(addr), exp_q.pop_front());
    end
  end
  task automatic cyc(logic [1:0] x, logic [1:0] y);
    x_count = x;
    y_count = y;
    @(posedge clk);
    #1;
  endtask
  task automatic stp(int exp);
    exp_q.push_back(exp);
    cyc(CNT_STEP, CNT_HOLD);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(CNT_HOLD, CNT_HOLD);
    reset = 1'b0;
  endtask
  task automatic chk_zero(string n);
    chk({n, "_outs"}, {x_16, y_16, addr_valid, frame_done}, 0);
    chk({n, "_mb_x"}, mb_x, 0);
    chk({n, "_mb_y"}, mb_y, 0);
    chk({n, "_addr"}, addr, 0);
  endtask
  initial begin
    do_reset();
    do_reset();
    chk_zero("reset");
    for (int k = 1; k <= 16; k++) begin
      stp(k - 1);
      chk("addr_valid_step", addr_valid, 1);
      chk("x_16_row", x_16, k == 15);
    end
    cyc(CNT_HOLD, CNT_HOLD);
    chk("addr_valid_hold", addr_valid, 0);
    cyc(CNT_CLEAR, CNT_NEXT);
    chk("addr_valid_rowcmd", addr_valid, 0);
    stp(352);
    // full macroblock scan then next-macroblock
    do_reset();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) stp(pix(0, 0, c, r));
      if (r < 15) cyc(CNT_CLEAR, CNT_NEXT);
    end
    chk("y_16_last_row", y_16, 1);
    cyc(CNT_NEXT, CNT_CLEAR);
    chk("mb_x_adv", mb_x, 1);
    chk("y_16_after_mb", y_16, 0);
    chk("x_16_after_mb", x_16, 0);
    stp(16);
    // frame wrap
    do_reset();
    for (int i = 0; i < 21 + 22 * 17; i++) cyc(CNT_NEXT, CNT_HOLD);
    chk("mb_x_last", mb_x, 21);
    chk("mb_y_last", mb_y, 17);
    chk("frame_done_early", frame_done, 0);
    cyc(CNT_NEXT, CNT_HOLD);
    chk("wrap_mb_x", mb_x, 0);
    chk("wrap_mb_y", mb_y, 0);
    chk("frame_done_pulse", frame_done, 1);
    cyc(CNT_HOLD, CNT_HOLD);
    chk("frame_done_end", frame_done, 0);
    stp(0);
    // row carry without frame wrap
    do_reset();
    for (int i = 0; i < 21 + 22 * 3; i++) cyc(CNT_NEXT, CNT_HOLD);
    cyc(CNT_NEXT, CNT_HOLD);
    chk("carry_mb_x", mb_x, 0);
    chk("carry_mb_y", mb_y, 4);
    chk("carry_no_done", frame_done, 0);
    stp(pix(0, 4, 0, 0));
    // hold, then reset together with a step
    do_reset();
    cyc(CNT_NEXT, CNT_HOLD);
    cyc(CNT_NEXT, CNT_HOLD);
    for (int i = 0; i < 5; i++) cyc(CNT_HOLD, CNT_STEP);
    for (int i = 0; i < 7; i++) stp(pix(2, 0, i, 5));
    for (int i = 0; i < 10; i++) begin
      cyc(CNT_HOLD, CNT_HOLD);
      chk("hold_valid", addr_valid, 0);
      chk("hold_mb_x", mb_x, 2);
      chk("hold_flags", {x_16, y_16}, 0);
    end
    stp(1799);
    reset = 1'b1;
    cyc(CNT_STEP, CNT_STEP);
    reset = 1'b0;
    chk_zero("midreset");
    stp(0);
    // simultaneous next-macroblock and row step
    do_reset();
    for (int i = 0; i < 3; i++) cyc(CNT_HOLD, CNT_STEP);
    cyc(CNT_NEXT, CNT_NEXT);
    chk("simul_mb_x", mb_x, 1);
    stp(1424);
    cyc(CNT_HOLD, CNT_HOLD);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mb_scan_counter.md
# mb_scan_counter

- Datapath counter that executes the 2-bit `x_count`/`y_count` commands issued by the data-handling scan controller.
- Tracks the current pixel position inside the current 16x16 macroblock, and the macroblock position inside the frame.
- Returns the `x_16`/`y_16` end-of-row and end-of-column flags that the controller branches on.
- Emits a registered, frame-linear pixel address with a valid strobe, which feeds the frame-buffer read port of the encoder front end.

## Interface
Parameters:
- `FRAME_W`, default 352: frame width in pixels; must be a multiple of 16.
- `FRAME_H`, default 288: frame height in pixels; must be a multiple of 16.
- `ADDR_W`, default `$clog2(FRAME_W*FRAME_H)` (17): pixel address width.

Ports (clock and reset first):
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `x_count`  in  2: column command.
- `y_count`  in  2: row command.
- `x_16`  out  1: high while `x_off == 15`.
- `y_16`  out  1: high while `y_off == 15`.
- `mb_x`  out  `$clog2(FRAME_W/16)`: current macroblock column.
- `mb_y`  out  `$clog2(FRAME_H/16)`: current macroblock row.
- `addr`  out  `ADDR_W`: registered pixel address.
- `addr_valid`  out  1: `addr` is a pixel to fetch this cycle.
- `frame_done`  out  1: one-cycle pulse on macroblock wrap from the last macroblock of the frame.

## Operation
- **State:** `x_off`, `y_off` (4 bits each, 0..15); `mb_x` (0..MBS_X-1); `mb_y` (0..MBS_Y-1).
  - MBS_X = FRAME_W/16 = 22.
  - MBS_Y = FRAME_H/16 = 18.
- **x_count commands:**
  - 00 clear: `x_off <= 0`.
  - 01 hold.
  - 10 step: `x_off <= x_off + 1`. 15 wraps to 0 with no carry into `mb_x`.
  - 11 next macroblock: `x_off <= 0`, `mb_x <= mb_x + 1`.
    - If `mb_x == MBS_X-1`: `mb_x <= 0`, and `mb_y` increments.
    - If `mb_y == MBS_Y-1` as well: `mb_y <= 0`, and `frame_done` pulses.
- **y_count commands:**
  - 00 clear: `y_off <= 0`.
  - 01 hold.
  - 10 step: `y_off <= y_off + 1`. 15 wraps to 0 with no carry.
  - 11 step: identical to 10 (the row-advance code the controller uses).
- **Simultaneous x=11 and y=10/11:** both apply in the same edge. The `mb_y` carry from x is independent of the `y_off` update.
- **Flags:** `x_16`/`y_16` are decoded directly from the registered offsets. There is no combinational path from the commands, so the controller's combinational next-state logic sees no loop.
- **Address:** `addr` is registered from the pre-update position, computed as ((mb_y*16 + y_off)*FRAME_W + mb_x*16 + x_off), truncated to `ADDR_W`.
  - Intermediate products are held at full width before truncation.
  - The maximum value, FRAME_W*FRAME_H-1 = 101375, fits in 17 bits.
- **addr_valid:** registered from (`x_count == 2'b10`). Every column-step cycle is a pixel fetch, including the step out of `x_off == 15`. Clear, hold and next-macroblock cycles do not fetch.
- **Reset values:** all counters 0; `x_16`, `y_16`, `addr`, `addr_valid`, `frame_done` all 0.
- **Reset mid-operation:** reset overrides any command in the same cycle. The next cycle restarts at pixel 0 of macroblock (0,0).

## Timing
- **Command latency:** a command sampled at edge N updates the counters at edge N. New `x_16`/`y_16`/`mb_x`/`mb_y` values are visible in the cycle after edge N.
- **Address latency:** `addr`/`addr_valid` for the position held during cycle N appear in cycle N+1 (1-cycle latency).
- **frame_done:** asserted exactly one cycle, the cycle after the wrapping x=11 command.
- **Controller row sequence:** 16 step cycles (10), then one row cycle (x=00, y=11). After `y_16`, one next-macroblock cycle (x=11, y=00).
  - Steady-state cost is 16*16 fetches + 16 overhead cycles per macroblock.

## Structure
- **Shared package `h264_dh_pkg`:**
  - Command enum with CNT_CLEAR=2'b00, CNT_HOLD=2'b01, CNT_STEP=2'b10, CNT_NEXT=2'b11.
  - Constant MB_SIZE=16.
  - Default frame dimensions. The existing controller's literals migrate to this enum.
- **Sub-module `mb_offset_counter`:** a 4-bit offset register with clear/hold/step/next decode and an `at_15` flag. It is instantiated twice, for x and y. The macroblock counters, carry chain and address logic live in the top level.

## Test plan
- **Reset, then 16 cycles of x=10/y=01:** `addr` 0..15 with `addr_valid` high in cycles 1..16; `x_16` high in the cycle after the 15th step, low after the 16th.
- **Row advance:** after a row, x=00/y=11, then x=10 → next fetched `addr` = 352; `y_off`=1.
- **Macroblock advance:** scan a full macroblock, then x=11/y=00 → `mb_x`=1; next fetched `addr` = 16; `y_16` low.
- **Frame wrap:** drive to `mb_x`=21, `mb_y`=17, then x=11 → `mb_x`=0, `mb_y`=0, `frame_done` one-cycle pulse. Also check `mb_x`=21, `mb_y`=3 → `mb_y`=4, no pulse.
- **Hold and reset:** hold at `x_off`=7, `y_off`=5, `mb_x`=2 for 10 cycles → no change and `addr_valid`=0. Then reset asserted together with x=10 → all outputs 0 next cycle.
- **Simultaneous commands:** x=11 with y=11 at `y_off`=3 → `y_off`=4, `mb_x`+1, `x_off`=0.
